// File: rtl/uart_rx_fifo_if.sv
// Bundle between the uart_rx / GPIO side and the receive FIFO.
// The master drives the byte strobe and the pop/clear strobes.
// The slave (the FIFO) returns the head byte and the status flags.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          rx_byte;
    logic                rx_byte_ready;
    logic                pop;
    logic                clear_overflow;
    logic [7:0]          dout;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;

    modport master (
        output rx_byte,
        output rx_byte_ready,
        output pop,
        output clear_overflow,
        input  dout,
        input  empty,
        input  full,
        input  count,
        input  overflow
    );

    modport slave (
        input  rx_byte,
        input  rx_byte_ready,
        input  pop,
        input  clear_overflow,
        output dout,
        output empty,
        output full,
        output count,
        output overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO for uart_rx bytes.
// A push happens once per rising edge of rx_byte_ready.
// A full FIFO drops the byte and raises a sticky overflow flag, unless a pop
// in the same cycle frees a slot.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_rx_fifo_if.slave    bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic                  ready_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            mem_q [DEPTH];

    logic is_empty, is_full;
    logic push_evt, pop_ok, push_ok, drop;

    // Event decode: edge-detected push, legal pop, and accept/drop decision.
    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == CNT_FULL);
        push_evt = bus.rx_byte_ready & ~ready_q;
        pop_ok   = bus.pop & ~is_empty;
        // A pop while full frees the slot that the push then takes.
        push_ok  = push_evt & (~is_full | pop_ok);
        drop     = push_evt & is_full & ~pop_ok;
    end

    // Next-state for pointers, occupancy and the sticky flag (set beats clear).
    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
        overflow_d = drop | (overflow_q & ~bus.clear_overflow);
    end

    // Control state: the only registers that reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ready_q    <= bus.rx_byte_ready;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.rx_byte;
        end
    end

    // Outputs derived from registered state; head reads as zero when empty.
    assign bus.dout     = is_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a random
// phase, all compared against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic clk;
    logic rst_n;

    uart_rx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Reference model state.
    logic [7:0] mq [$];
    bit         m_ready;
    bit         m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("dout",     32'(bus.dout),     (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
        chk("empty",    32'(bus.empty),    32'(mq.size() == 0));
        chk("full",     32'(bus.full),     32'(mq.size() == DEPTH));
        chk("count",    32'(bus.count),    32'(mq.size()));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_ready = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Apply one clock with the current inputs, update the model, then check.
    task automatic step();
        bit push, popv, dropped;
        int sz;
        push    = bus.rx_byte_ready && !m_ready;
        sz      = mq.size();
        popv    = bus.pop && (sz > 0);
        dropped = 1'b0;
        if (popv) void'(mq.pop_front());
        if (push) begin
            if (sz < DEPTH || popv) mq.push_back(bus.rx_byte);
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (bus.clear_overflow) m_ovf = 1'b0;
        m_ready = bus.rx_byte_ready;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic push_pulse(input logic [7:0] b);
        bus.rx_byte       = b;
        bus.rx_byte_ready = 1'b1;
        step();
        bus.rx_byte_ready = 1'b0;
        step();
    endtask

    task automatic pop_once();
        bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
    endtask

    initial begin
        rst_n                  = 1'b0;
        bus.rx_byte            = 8'h00;
        bus.rx_byte_ready      = 1'b0;
        bus.pop                = 1'b0;
        bus.clear_overflow     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Three spaced pulses, then drain.
        push_pulse(8'h41);
        repeat (4) step();
        push_pulse(8'h42);
        repeat (4) step();
        push_pulse(8'h43);
        chk("three_count", 32'(bus.count), 32'd3);
        chk("three_head",  32'(bus.dout),  32'h41);
        pop_once();
        chk("pop1_dout", 32'(bus.dout), 32'h42);
        pop_once();
        chk("pop2_dout", 32'(bus.dout), 32'h43);
        pop_once();
        chk("pop3_dout",  32'(bus.dout),  32'h00);
        chk("pop3_empty", 32'(bus.empty), 32'd1);

        // Long level on rx_byte_ready stores one byte.
        bus.rx_byte       = 8'h55;
        bus.rx_byte_ready = 1'b1;
        repeat (20) step();
        bus.rx_byte_ready = 1'b0;
        step();
        chk("level_count", 32'(bus.count), 32'd1);
        pop_once();

        // Fill past capacity.
        for (int i = 0; i <= DEPTH; i++) push_pulse(8'(i));
        chk("fill_full",  32'(bus.full),     32'd1);
        chk("fill_ovf",   32'(bus.overflow), 32'd1);
        chk("fill_count", 32'(bus.count),    32'(DEPTH));
        bus.clear_overflow = 1'b1;
        step();
        bus.clear_overflow = 1'b0;
        chk("clr_ovf", 32'(bus.overflow), 32'd0);

        // Push with pop while full: accepted, no overflow.
        bus.rx_byte       = 8'hAA;
        bus.rx_byte_ready = 1'b1;
        bus.pop           = 1'b1;
        step();
        bus.rx_byte_ready = 1'b0;
        bus.pop           = 1'b0;
        step();
        chk("pp_full_count", 32'(bus.count),    32'(DEPTH));
        chk("pp_full_ovf",   32'(bus.overflow), 32'd0);
        chk("pp_full_head",  32'(bus.dout),     32'h01);

        // Drop a byte, then drop with a simultaneous clear: set wins.
        push_pulse(8'hBB);
        chk("drop_ovf", 32'(bus.overflow), 32'd1);
        bus.rx_byte            = 8'hCC;
        bus.rx_byte_ready      = 1'b1;
        bus.clear_overflow     = 1'b1;
        step();
        bus.rx_byte_ready      = 1'b0;
        bus.clear_overflow     = 1'b0;
        chk("setwins_ovf", 32'(bus.overflow), 32'd1);
        bus.clear_overflow = 1'b1;
        step();
        bus.clear_overflow = 1'b0;
        chk("clr_alone_ovf", 32'(bus.overflow), 32'd0);

        // Drain: 01..0F then AA.
        for (int i = 1; i < DEPTH; i++) begin
            chk("drain_seq", 32'(bus.dout), 32'(i));
            pop_once();
        end
        chk("drain_last", 32'(bus.dout), 32'hAA);
        pop_once();
        chk("drain_empty", 32'(bus.empty), 32'd1);
        pop_once();
        chk("pop_empty_count", 32'(bus.count),    32'd0);
        chk("pop_empty_ovf",   32'(bus.overflow), 32'd0);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 5; i++) push_pulse(8'(8'h20 + i));
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_empty", 32'(bus.empty), 32'd1);
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_dout",  32'(bus.dout),  32'h00);
        bus.rx_byte       = 8'h7E;
        bus.rx_byte_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_dout", 32'(bus.dout), 32'h7E);
        bus.rx_byte_ready = 1'b0;
        step();
        pop_once();

        // Random phase: low pop rate first to reach full, then higher.
        for (int c = 0; c < 3000; c++) begin
            bus.rx_byte            = 8'($urandom);
            bus.rx_byte_ready      = ($urandom_range(99) < 50);
            bus.pop                = ($urandom_range(99) < ((c < 1500) ? 10 : 35));
            bus.clear_overflow     = ($urandom_range(99) < 5);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
